// File: rtl/alu_op_sequencer_if.sv
// Request/response channel bundle between two requesters, the sequencer and its consumer.
interface alu_op_sequencer_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_op;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_op;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_id;
  logic [2:0]  rsp_op;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_op
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_op
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Two-port scheduler sharing one 8-bit ALU / radix-2 Booth multiplier,
// returning a tagged 16-bit result over a valid/ready response channel.
module alu_op_sequencer #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_sequencer_if.slave   bus,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic        grant;
  logic        ready0, ready1;
  logic        accept;
  logic [2:0]  sel_op;
  logic [7:0]  sel_a, sel_b;

  logic [2:0]  op_q;
  logic        id_q;
  logic [7:0]  a_q, b_q;
  logic [15:0] data_q;
  logic [15:0] exec_result;

  // Booth accumulator carries a guard bit so -128 * -128 does not overflow.
  logic [8:0]  acc;
  logic [7:0]  mq;
  logic        q_1;
  logic [3:0]  count;
  logic [8:0]  m_ext;
  logic [8:0]  acc_sum;
  logic [8:0]  acc_sh;
  logic [7:0]  mq_sh;
  logic        q1_sh;

  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      grant = FIXED_PRIORITY ? 1'b0 : ~last_grant;
    else if (bus.req1_valid)
      grant = 1'b1;
  end

  assign sel_op = grant ? bus.req1_op : bus.req0_op;
  assign sel_a  = grant ? bus.req1_a  : bus.req0_a;
  assign sel_b  = grant ? bus.req1_b  : bus.req0_b;

  always_comb begin
    state_nxt = state;
    ready0    = 1'b0;
    ready1    = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          ready0 = bus.req0_valid && !grant;
          ready1 = bus.req1_valid &&  grant;
        end
        accept = ready0 || ready1;
        if (accept)
          state_nxt = (sel_op == 3'd7) ? MUL : EXEC;
      end
      EXEC: state_nxt = RESP;
      MUL:  if (count == 4'd7) state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    exec_result = '0;
    case (op_q)
      3'd0: exec_result = {8'h00, a_q};
      3'd1: exec_result = {8'h00, ~a_q};
      3'd2: exec_result = {8'h00, a_q & b_q};
      3'd3: exec_result = {8'h00, a_q | b_q};
      3'd4: exec_result = {8'h00, a_q ^ b_q};
      3'd5: exec_result = {7'b0, {1'b0, a_q} + {1'b0, b_q}};
      3'd6: exec_result = {8'h00, a_q - b_q};
      default: exec_result = '0;
    endcase
  end

  assign m_ext = {a_q[7], a_q};

  always_comb begin
    acc_sum = acc;
    case ({mq[0], q_1})
      2'b01:   acc_sum = acc + m_ext;
      2'b10:   acc_sum = acc - m_ext;
      default: acc_sum = acc;
    endcase
    {acc_sh, mq_sh, q1_sh} = {acc_sum[8], acc_sum, mq};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      op_q       <= '0;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      data_q     <= '0;
      acc        <= '0;
      mq         <= '0;
      q_1        <= 1'b0;
      count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= sel_op;
            id_q       <= grant;
            a_q        <= sel_a;
            b_q        <= sel_b;
            last_grant <= grant;
            acc        <= '0;
            mq         <= sel_b;
            q_1        <= 1'b0;
            count      <= '0;
          end
        end
        EXEC: data_q <= exec_result;
        MUL: begin
          acc   <= acc_sh;
          mq    <= mq_sh;
          q_1   <= q1_sh;
          count <= count + 4'd1;
          if (count == 4'd7)
            data_q <= {acc_sh[7:0], mq_sh};
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_data   = data_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_op     = op_q;
  assign busy           = (state != IDLE);

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Two-port request scheduler that shares one 8-bit ALU/multiplier datapath between two requesters. It arbitrates incoming operation requests, latches operands, runs either a single-cycle logic/arithmetic op or an 8-step radix-2 Booth signed multiply, and returns a 16-bit tagged result over a valid/ready response channel. It sits between the requesting masters and the ALU function set, with opcode encoding identical to the ALU result mux.

## Interface
- FIXED_PRIORITY, 0, 0 = round-robin between ports; 1 = port 0 always wins when both are valid
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req0_valid / req1_valid  in  1  request present on port 0 / port 1
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- req0_op / req1_op  in  3  opcode: 0 copy A, 1 complement A, 2 AND, 3 OR, 4 XOR, 5 add, 6 sub, 7 signed multiply
- req0_a, req0_b / req1_a, req1_b  in  8  operands
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_data  out  16  result
- rsp_id  out  1  port that issued the request
- rsp_op  out  3  opcode of the returned result
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, EXEC, MUL, RESP.
- IDLE: grant is computed from the valid inputs. req_ready is asserted only to the granted port and only when that port is valid. Any other ready output stays low. On the handshake edge the block latches op, a, b and id, and records last_grant. The next state is MUL for op 7 and EXEC for every other op.
- Arbitration:
  - Round-robin: when both ports are valid, the port not equal to last_grant wins. last_grant resets to 1, so port 0 wins first.
  - FIXED_PRIORITY=1: port 0 always wins.
  - A single valid port always wins.
- EXEC (one cycle): the block computes the result into rsp_data and moves to RESP. Results per op:
  - 0: {8'h00, a}
  - 1: {8'h00, ~a}, with all 8 bits inverted bitwise
  - 2, 3, 4: {8'h00, a&b}, {8'h00, a|b}, {8'h00, a^b}
  - 5: {7'b0, carry, (a+b)[7:0]}
  - 6: {8'h00, (a-b) mod 256}, i.e. two's complement a + ~b + 1
- MUL, load on the acceptance edge: A=0, M=a, Q=b, Q_1=0, count=0.
- MUL, each following edge:
  - If {Q[0],Q_1}=01: A=A+M.
  - If {Q[0],Q_1}=10: A=A-M.
  - Otherwise A is unchanged.
  - Then arithmetic right shift of {A,Q,Q_1} by 1, and count++.
  - On the edge where count goes 7→8, rsp_data={A,Q} after the shift and the state moves to RESP.
  - The result equals signed(a)×signed(b), sign-extended to 16 bits.
- RESP: rsp_valid=1. rsp_data, rsp_id and rsp_op are held stable until the rsp_valid & rsp_ready edge, then the state moves to IDLE. No new request is accepted in RESP.
- Reset (any time, including mid-multiply or during RESP):
  - Immediately forces IDLE and drops any in-flight result.
  - last_grant=1; count=0; rsp_valid=0; rsp_data=0; rsp_id=0; rsp_op=0; busy=0.
  - req_ready outputs are 0 while rst_n=0.

## Timing
- Non-multiply op accepted at edge k: rsp_valid is high after edge k+1.
- Multiply accepted at edge k: rsp_valid is high after edge k+8, i.e. 8 Booth steps.
- busy rises after the acceptance edge and falls after the response handshake edge.
- Response handshake at edge r: the block is IDLE after r and can accept again at edge r+1. No accept happens in the same cycle as a handshake.
- Peak throughput with rsp_ready held high:
  - one non-multiply op every 3 cycles
  - one multiply every 10 cycles
- A requester that drops valid before ready is not granted. Its pending op is never latched.
- Arbitration grant and ready depend only on the current valid inputs, state and last_grant.

## Test plan
- Reset, then port 0 requests add with a=8'hFF, b=8'h01 → rsp_data=16'h0100, rsp_id=0, rsp_op=5, rsp_valid after 2 edges, busy high for those 2 cycles.
- Port 1 multiplies a=8'hFD, b=8'h05 → 16'hFFF1 after 9 edges. Then a=8'h80, b=8'h80 → 16'h4000. Then a=8'h7F, b=8'h80 → 16'hC080. busy stays high throughout each multiply.
- Both ports continuously valid: port 0 issues AND 8'hF0 & 8'h3C, port 1 issues sub 8'h05 − 8'h07.
  - Grants alternate 0,1,0,1.
  - Responses alternate 16'h0030 (id 0) and 16'h00FE (id 1).
- Back-pressure: rsp_ready held low for 5 cycles with a complement of 8'h5A pending.
  - rsp_data stays 16'h00A5 and stable.
  - Both req_ready outputs stay low while requests are pending.
  - When rsp_ready rises, the handshake completes and the next accept occurs one edge later.
- rst_n asserted while the multiply count is 4 → rsp_valid=0, busy=0 and rsp_data=0 immediately, and no response is ever issued. After release with both ports valid, port 0 is granted first.
- FIXED_PRIORITY=1 with both ports continuously valid → port 1 is never granted. When port 0 deasserts valid, port 1 is granted on the next IDLE cycle. Port 1 copy of a=8'h3C → 16'h003C.
